// File: rtl/bank_cmd_arbiter.sv
// Bank command arbiter: picks one bank request per cycle by priority with a
// round-robin tie-break, broadcasts it one cycle later and enforces tRRD/tFAW on ACTs.
module bank_cmd_arbiter #(
   parameter int NUM_BANKS      = 16,
   parameter int PRIO_W         = 2,
   parameter int ROW_ADDR_WIDTH = 16,
   parameter int ROW_W          = ROW_ADDR_WIDTH,
   localparam int BK_ADDR_WIDTH = $clog2(NUM_BANKS),
   localparam int CMD_W         = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [3:0]                 cfg_trrd,
   input  logic [5:0]                 cfg_tfaw,
   input  logic [NUM_BANKS-1:0]       bke_req,
   input  logic [NUM_BANKS*PRIO_W-1:0] bke_prio,
   input  logic [NUM_BANKS*CMD_W-1:0] bke_cmd,
   input  logic [NUM_BANKS*ROW_W-1:0] bke_row,
   output logic [NUM_BANKS-1:0]       bkarb_ack,
   output logic [CMD_W-1:0]           bkarb_cmd,
   output logic [BK_ADDR_WIDTH-1:0]   bkarb_cmd_bk,
   output logic [ROW_W-1:0]           bkarb_cmd_row,
   output logic                       bkarb_cmd_valid
);

   typedef enum logic [2:0] {
      NOP1  = 3'd0,
      ACT   = 3'd1,
      RD    = 3'd2,
      WDM   = 3'd3,
      PREPB = 3'd4,
      PREAB = 3'd5,
      REFPB = 3'd6
   } cmd_t;

   logic [BK_ADDR_WIDTH-1:0] rr_ptr;
   logic [BK_ADDR_WIDTH-1:0] win_idx;
   logic [BK_ADDR_WIDTH-1:0] scan_idx;
   logic [PRIO_W-1:0]        win_prio;
   logic [PRIO_W-1:0]        scan_prio;
   logic                     found;
   logic [NUM_BANKS-1:0]     eligible;
   logic                     act_gate_open;
   logic [CMD_W-1:0]         win_cmd;
   logic [ROW_W-1:0]         win_row;
   logic                     act_issue;
   logic [3:0]               trrd_cnt;
   logic [3:0]               trrd_load;
   logic [5:0]               faw_cnt [4];
   logic [5:0]               faw_load_val;
   logic [3:0]               faw_load;
   logic                     faw_taken;

   // Counters hold the number of cycles the gate must still stay shut, so a
   // setting of 0 or 1 loads nothing; a bank just granted is skipped as stale.
   always_comb begin
      act_gate_open = (trrd_cnt == 4'd0) &&
                      ((faw_cnt[0] == 6'd0) || (faw_cnt[1] == 6'd0) ||
                       (faw_cnt[2] == 6'd0) || (faw_cnt[3] == 6'd0));
      for (int i = 0; i < NUM_BANKS; i++) begin
         eligible[i] = bke_req[i] && !bkarb_ack[i] &&
                       (bke_cmd[i*CMD_W +: CMD_W] != NOP1) &&
                       ((bke_cmd[i*CMD_W +: CMD_W] != ACT) || act_gate_open);
      end
   end

   // Scanning from rr_ptr and only replacing on strictly higher priority
   // leaves the first eligible bank in rotation order as the tie winner.
   always_comb begin
      found     = 1'b0;
      win_idx   = '0;
      win_prio  = '0;
      scan_idx  = '0;
      scan_prio = '0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         scan_idx  = rr_ptr + BK_ADDR_WIDTH'(k);
         scan_prio = bke_prio[scan_idx*PRIO_W +: PRIO_W];
         if (eligible[scan_idx] && (!found || (scan_prio > win_prio))) begin
            found    = 1'b1;
            win_idx  = scan_idx;
            win_prio = scan_prio;
         end
      end
   end

   always_comb begin
      win_cmd      = bke_cmd[win_idx*CMD_W +: CMD_W];
      win_row      = bke_row[win_idx*ROW_W +: ROW_W];
      act_issue    = found && (win_cmd == ACT);
      trrd_load    = (cfg_trrd > 4'd1) ? cfg_trrd - 4'd1 : 4'd0;
      faw_load_val = (cfg_tfaw > 6'd1) ? cfg_tfaw - 6'd1 : 6'd0;
      faw_load     = '0;
      faw_taken    = 1'b0;
      for (int j = 0; j < 4; j++) begin
         if ((faw_cnt[j] == 6'd0) && !faw_taken) begin
            faw_load[j] = 1'b1;
            faw_taken   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bkarb_ack       <= '0;
         bkarb_cmd_valid <= 1'b0;
         bkarb_cmd       <= NOP1;
         bkarb_cmd_bk    <= '0;
         bkarb_cmd_row   <= '0;
         rr_ptr          <= '0;
         trrd_cnt        <= '0;
         for (int j = 0; j < 4; j++) faw_cnt[j] <= '0;
      end else begin
         bkarb_ack       <= '0;
         bkarb_cmd_valid <= found;
         bkarb_cmd       <= NOP1;
         if (found) begin
            bkarb_ack[win_idx] <= 1'b1;
            bkarb_cmd          <= win_cmd;
            bkarb_cmd_bk       <= win_idx;
            bkarb_cmd_row      <= win_row;
            rr_ptr             <= win_idx + BK_ADDR_WIDTH'(1);
         end
         if (act_issue)
            trrd_cnt <= trrd_load;
         else if (trrd_cnt != 4'd0)
            trrd_cnt <= trrd_cnt - 4'd1;
         for (int j = 0; j < 4; j++) begin
            if (act_issue && faw_load[j])
               faw_cnt[j] <= faw_load_val;
            else if (faw_cnt[j] != 6'd0)
               faw_cnt[j] <= faw_cnt[j] - 6'd1;
         end
      end
   end

endmodule

// File: doc/bank_cmd_arbiter.md
BANK_CMD_ARBITER -- requirements
Module: bank_cmd_arbiter

Interface
REQ-001 Parameter NUM_BANKS, default 16: number of bank engines served; power of two, 2..32.
REQ-002 Parameter PRIO_W, default 2: width of each requester priority field.
REQ-003 Parameter ROW_W, default ROW_ADDR_WIDTH: row address width.
REQ-004 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-low.
REQ-006 Port cfg_trrd, input, 4: minimum ACT-to-ACT spacing in cycles; quasi-static.
REQ-007 Port cfg_tfaw, input, 6: four-activate window in cycles; quasi-static.
REQ-008 Port bke_req, input, NUM_BANKS: per-bank command request.
REQ-009 Port bke_prio, input, NUM_BANKS x PRIO_W: per-bank request priority.
REQ-010 Port bke_cmd, input, NUM_BANKS x $bits(cmd_t): per-bank requested command.
REQ-011 Port bke_row, input, NUM_BANKS x ROW_W: per-bank row address.
REQ-012 Port bkarb_ack, output, NUM_BANKS: one-hot grant pulse.
REQ-013 Port bkarb_cmd, output, $bits(cmd_t): broadcast command.
REQ-014 Port bkarb_cmd_bk, output, BK_ADDR_WIDTH: broadcast bank index.
REQ-015 Port bkarb_cmd_row, output, ROW_W: broadcast row address.
REQ-016 Port bkarb_cmd_valid, output, 1: broadcast qualifier.

Function
REQ-017 Bank i is eligible in cycle t if bke_req[i]=1, bke_cmd[i]!=NOP1, bkarb_ack[i]=0 in cycle t (stale request), and, if bke_cmd[i]==ACT, the ACT gate (REQ-022/023) is open.
REQ-018 Winner: highest bke_prio among eligible banks; ties go to the first eligible index at or above rr_ptr, wrapping NUM_BANKS-1 -> 0.
REQ-019 Latency one cycle: winner selected in cycle t yields, in cycle t+1, bkarb_ack[winner]=1, bkarb_cmd_valid=1, and bkarb_cmd/bk/row equal to the winner's cycle-t inputs.
REQ-020 At most one grant and one broadcast per cycle; bkarb_ack is one-hot or zero.
REQ-021 No eligible bank in cycle t: in t+1 bkarb_ack=0, bkarb_cmd_valid=0, bkarb_cmd=NOP1, bkarb_cmd_bk/row hold their previous values.
REQ-022 tRRD: after an ACT broadcast in cycle c, no ACT is broadcast before cycle c+cfg_trrd; cfg_trrd 0 or 1 imposes no restriction.
REQ-023 tFAW: four window counters; each broadcast ACT loads a free counter with cfg_tfaw, and each nonzero counter decrements every cycle; ACT is gated while all four are nonzero, so the fifth ACT broadcasts no earlier than first-ACT cycle + cfg_tfaw.
REQ-024 Gated ACT requests do not block other commands; a lower-priority non-ACT request wins while a higher-priority ACT is gated.
REQ-025 rr_ptr updates to (winner+1) mod NUM_BANKS on each grant and holds otherwise.
REQ-026 Broadcasts of RD, WDM, PREPB, PREAB and REFPB do not affect the tRRD or tFAW state.
REQ-027 Changing cfg_trrd or cfg_tfaw while timers run affects only subsequently loaded counters.

Reset
REQ-028 While rst=0 at a clock edge: bkarb_ack=0, bkarb_cmd_valid=0, bkarb_cmd=NOP1, bkarb_cmd_bk=0, bkarb_cmd_row=0, rr_ptr=0, all tRRD/tFAW counters=0.
REQ-029 Reset asserted mid-operation discards the pending grant; outputs take reset values at the next edge and the first post-reset grant appears one cycle after the first eligible cycle.

Verification
REQ-030 Banks 3 and 7 request RD at prio 1 from cycle 0 -> ack[3] at cycle 1, ack[7] at cycle 2 (bank 3 excluded as stale), rr_ptr=8.
REQ-031 Bank 2 requests RD at prio 1 and bank 9 requests REFPB at prio 3 -> bank 9 granted first; bkarb_cmd=REFPB, bkarb_cmd_bk=9.
REQ-032 cfg_trrd=4, ACTs pending on banks 0, 1 and 2 -> ACT broadcasts in cycles 1, 5 and 9; a bank-5 RD request arriving in cycle 2 is broadcast in cycle 3.
REQ-033 cfg_trrd=1, cfg_tfaw=20, five banks request ACT continuously -> ACTs in cycles 1, 2, 3 and 4; fifth ACT in cycle 21.
REQ-034 rr_ptr=15, equal-priority requests on banks 15 and 0 -> grant 15, then 0 (wrap), rr_ptr=1.
REQ-035 rst=0 in the cycle after a grant decision -> at the next edge bkarb_cmd_valid=0, ack=0 and bkarb_cmd=NOP1; no broadcast is issued for the discarded grant.
